// File: rtl/neuron_membrane_integrator.sv
// Integrate-and-fire controller: drives V and a held weight into an external
// ripple-carry adder, waits for it to settle, saturates the sum back into V.
`timescale 1ns/1ps

module neuron_membrane_integrator #(
  parameter int         SETTLE_CYC  = 2,
  parameter int         REFRACT_CYC = 3,
  parameter logic [7:0] LEAK        = 8'd1,
  parameter int         LEAK_PERIOD = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] W_IN,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] TH,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       Cin,
  input  logic [7:0] Sout,
  input  logic       Cout,
  output logic       SPIKE,
  output logic [7:0] V_OUT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    FIRE,
    REFRACT
  } state_t;

  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] REFRACT_LAST = 4'(REFRACT_CYC - 1);
  localparam logic [7:0] LEAK_LAST    = 8'(LEAK_PERIOD - 1);

  state_t     state;
  logic [7:0] v;
  logic [7:0] weight;
  logic [3:0] settle_cnt;
  logic [3:0] refract_cnt;
  logic [7:0] leak_cnt;
  logic       spike_q;
  logic       ready_q;
  logic       busy_q;
  logic [7:0] nv;

  // A carry-out means the true sum exceeded 255, so clamp instead of wrapping.
  assign nv = Cout ? 8'hFF : Sout;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; ready/busy/spike are registered alongside each transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      v           <= '0;
      weight      <= '0;
      settle_cnt  <= '0;
      refract_cnt <= '0;
      leak_cnt    <= '0;
      spike_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            weight     <= W_IN;
            settle_cnt <= '0;
            leak_cnt   <= '0;
            state      <= SETTLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end else if (leak_cnt == LEAK_LAST) begin
            leak_cnt <= '0;
            v        <= (v > LEAK) ? v - LEAK : '0;
          end else begin
            leak_cnt <= leak_cnt + 8'd1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
          else settle_cnt <= settle_cnt + 4'd1;
        end
        CAPTURE: begin
          v <= nv;
          if (nv >= TH) begin
            state   <= FIRE;
            spike_q <= 1'b1;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        FIRE: begin
          v           <= '0;
          refract_cnt <= '0;
          if (REFRACT_CYC == 0) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state <= REFRACT;
          end
        end
        REFRACT: begin
          if (refract_cnt == REFRACT_LAST) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            refract_cnt <= refract_cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A        = v;
  assign B        = weight;
  assign Cin      = 1'b0;
  assign V_OUT    = v;
  assign SPIKE    = spike_q;
  assign IN_READY = ready_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_neuron_membrane_integrator.sv
// Directed bench for neuron_membrane_integrator with a behavioural adder that
// shows garbage until its operands have been stable for a cycle.
`timescale 1ns/1ps

module tb_neuron_membrane_integrator;

  localparam int SETTLE  = 2;
  localparam int REFRACT = 3;

  logic       CLK = 1'b0;
  logic       RST;
  always #5 CLK = ~CLK;

  // Main instance (default parameters)
  logic [7:0] w_in, th, a, b, sout, v_out;
  logic       in_valid, in_ready, cin, cout, spike, busy;
  logic [7:0] a_q, b_q;
  logic [8:0] sum1;

  // Back-to-back instance (no refractory period)
  logic [7:0] b2_w, b2_th, b2_a, b2_b, b2_sout, b2_vout;
  logic       b2_valid, b2_ready, b2_cin, b2_cout, b2_spike, b2_busy;
  logic [7:0] b2_a_q, b2_b_q;
  logic [8:0] sum2;

  neuron_membrane_integrator #(
    .SETTLE_CYC(SETTLE), .REFRACT_CYC(REFRACT), .LEAK(8'd1), .LEAK_PERIOD(16)
  ) u_dut (
    .CLK(CLK), .RST(RST), .W_IN(w_in), .IN_VALID(in_valid), .IN_READY(in_ready),
    .TH(th), .A(a), .B(b), .Cin(cin), .Sout(sout), .Cout(cout),
    .SPIKE(spike), .V_OUT(v_out), .BUSY(busy)
  );

  neuron_membrane_integrator #(
    .SETTLE_CYC(SETTLE), .REFRACT_CYC(0), .LEAK(8'd1), .LEAK_PERIOD(16)
  ) u_b2b (
    .CLK(CLK), .RST(RST), .W_IN(b2_w), .IN_VALID(b2_valid), .IN_READY(b2_ready),
    .TH(b2_th), .A(b2_a), .B(b2_b), .Cin(b2_cin), .Sout(b2_sout), .Cout(b2_cout),
    .SPIKE(b2_spike), .V_OUT(b2_vout), .BUSY(b2_busy)
  );

  // Adder models: inverted (unsettled) output the first cycle after an operand change.
  always @(posedge CLK) begin
    a_q    <= a;
    b_q    <= b;
    b2_a_q <= b2_a;
    b2_b_q <= b2_b;
  end
  assign sum1 = {1'b0, a} + {1'b0, b};
  assign {cout, sout} = (a == a_q && b == b_q) ? sum1 : ~sum1;
  assign sum2 = {1'b0, b2_a} + {1'b0, b2_b};
  assign {b2_cout, b2_sout} = (b2_a == b2_a_q && b2_b == b2_b_q) ? sum2 : ~sum2;

  typedef struct packed {
    logic [7:0] nv;
    logic       fire;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] v_model;
  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 16'(in_ready), 16'd1);
  endtask

  // Handshake w in the current cycle t, then check through cycle t+2+SETTLE.
  task automatic send(input logic [7:0] w);
    exp_t       e;
    logic [8:0] s;
    wait_ready("ready_before_send");
    w_in     = w;
    in_valid = 1'b1;
    s        = {1'b0, v_model} + {1'b0, w};
    e.nv     = s[8] ? 8'hFF : s[7:0];
    e.fire   = (e.nv >= th);
    sb.push_back(e);
    v_model  = e.fire ? 8'd0 : e.nv;
    @(negedge CLK);
    in_valid = 1'b0;
    check("b_loaded", 16'(b), 16'(w));
    check("ready_low_settle", 16'(in_ready), 16'd0);
    repeat (SETTLE) @(negedge CLK);
    check("busy_capture", 16'(busy), 16'd1);
    @(negedge CLK);
    e = sb.pop_front();
    check("v_out", 16'(v_out), 16'(e.nv));
    check("a_out", 16'(a), 16'(e.nv));
    check("spike", 16'(spike), 16'(e.fire));
    check("ready_after", 16'(in_ready), 16'(!e.fire));
  endtask

  initial begin
    RST      = 1'b1;
    in_valid = 1'b0;
    w_in     = 8'd0;
    th       = 8'd100;
    b2_valid = 1'b0;
    b2_w     = 8'd0;
    b2_th    = 8'd0;
    v_model  = 8'd0;

    // Reset state
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_v", 16'(v_out), 16'd0);
    check("rst_b", 16'(b), 16'd0);
    check("rst_spike", 16'(spike), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ready", 16'(in_ready), 16'd1);
    check("cin_zero", 16'(cin), 16'd0);

    // Single input, then accumulate to 80 and cross threshold with 30
    send(8'd40);
    send(8'd40);
    send(8'd30);
    in_valid = 1'b1;
    w_in     = 8'd77;
    for (int i = 0; i < REFRACT; i++) begin
      @(negedge CLK);
      check("refract_ready", 16'(in_ready), 16'd0);
      check("refract_spike", 16'(spike), 16'd0);
      check("refract_v", 16'(v_out), 16'd0);
      check("refract_b", 16'(b), 16'd30);
    end
    @(negedge CLK);
    check("refract_done_ready", 16'(in_ready), 16'd1);
    in_valid = 1'b0;
    @(negedge CLK);
    check("refract_no_accept", 16'(b), 16'd30);
    check("refract_idle", 16'(busy), 16'd0);

    // Saturation: 200 + 100 clamps to 255, which fires at TH=255
    th = 8'd255;
    send(8'd200);
    send(8'd100);
    th = 8'd100;

    // Leak from 3 down to 0, no wrap
    send(8'd3);
    repeat (15) @(negedge CLK);
    check("leak_15", 16'(v_out), 16'd3);
    @(negedge CLK);
    check("leak_16", 16'(v_out), 16'd2);
    repeat (16) @(negedge CLK);
    check("leak_32", 16'(v_out), 16'd1);
    repeat (16) @(negedge CLK);
    check("leak_48", 16'(v_out), 16'd0);
    repeat (16) @(negedge CLK);
    check("leak_64", 16'(v_out), 16'd0);
    v_model = 8'd0;

    // Handshake on the leak cycle suppresses the leak
    send(8'd5);
    repeat (15) @(negedge CLK);
    send(8'd0);

    // Reset during SETTLE with V=50
    send(8'd45);
    wait_ready("ready_before_rst");
    w_in     = 8'd20;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    check("midrst_busy_before", 16'(busy), 16'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_v", 16'(v_out), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_ready", 16'(in_ready), 16'd1);
    check("midrst_spike", 16'(spike), 16'd0);
    check("midrst_b", 16'(b), 16'd0);
    v_model = 8'd0;
    send(8'd10);

    // Back-to-back, REFRACT_CYC=0, TH=0: every handshake fires
    begin
      int   spikes, first, last, overlaps;
      logic prev;
      spikes   = 0;
      first    = -1;
      last     = -1;
      overlaps = 0;
      prev     = 1'b0;
      b2_w     = 8'd1;
      b2_valid = 1'b1;
      for (int i = 1; i <= 60; i++) begin
        @(negedge CLK);
        if (b2_spike === 1'b1) begin
          if (prev) overlaps++;
          if (last >= 0) check("b2b_gap", 16'(i - last), 16'(SETTLE + 3));
          else first = i;
          check("b2b_vout", 16'(b2_vout), 16'd1);
          last = i;
          spikes++;
        end
        prev = b2_spike;
      end
      b2_valid = 1'b0;
      check("b2b_first", 16'(first), 16'(SETTLE + 2));
      check("b2b_count", 16'(spikes), 16'd12);
      check("b2b_overlap", 16'(overlaps), 16'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
